// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard / stall / flush controller for a classic 5-stage pipeline.
// Decides, each cycle, whether the front of the pipe freezes, whether IF/ID is
// flushed, whether a bubble is injected into ID/EX and whether the back end
// (EX/MEM, MEM/WB) holds while a data-memory access is outstanding.
//
// Parameters
//   FORWARD_EN : 1 = forwarding unit present, only an EX-stage load hazards
//                0 = any pending EX/MEM write to a source register hazards
//   FLUSH_CYC  : IF/ID flush cycles per taken branch (1..3)
//
// Ports
//   clk, rst                 clock, async active-low reset (sync release)
//   id_src1/id_src2/id_two_src   ID-stage source operands
//   ex_dest/ex_mem_read/ex_wb_en EX-stage destination info
//   mem_dest/mem_wb_en           MEM-stage destination info
//   branch_taken                 taken branch / jump resolved this cycle
//   dmem_req/dmem_ready          MEM-stage data access and its completion
//   imem_ready                   instruction fetch data valid
//   pc_freeze .. ex_mem_freeze   combinational pipeline controls
//   state                        FSM state (RUN=0, DWAIT=1, FLUSH=2)
//   stall_cnt/flush_cnt          saturating performance counters
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int FORWARD_EN = 1,
   parameter int FLUSH_CYC  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_src1,
   input  logic [4:0]  id_src2,
   input  logic        id_two_src,
   input  logic [4:0]  ex_dest,
   input  logic        ex_mem_read,
   input  logic        ex_wb_en,
   input  logic [4:0]  mem_dest,
   input  logic        mem_wb_en,
   input  logic        branch_taken,
   input  logic        dmem_req,
   input  logic        dmem_ready,
   input  logic        imem_ready,
   output logic        pc_freeze,
   output logic        if_id_freeze,
   output logic        if_id_flush,
   output logic        id_ex_bubble,
   output logic        ex_mem_freeze,
   output logic [1:0]  state,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DWAIT = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   // Remaining flush cycles after the first one, loaded on every taken branch.
   localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYC - 1);

   state_e      state_q, state_d;
   logic [1:0]  fcnt_q, fcnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;
   logic        flush_inc_s;
   logic        ex_match_s;
   logic        mem_match_s;
   logic        hazard_s;

   // Operand matches against EX/MEM destinations; register 0 never hazards.
   always_comb begin
      ex_match_s  = (ex_dest != 5'd0) &&
                    ((ex_dest == id_src1) || (id_two_src && (ex_dest == id_src2)));
      mem_match_s = (mem_dest != 5'd0) &&
                    ((mem_dest == id_src1) || (id_two_src && (mem_dest == id_src2)));
      if (FORWARD_EN != 0) begin
         hazard_s = ex_mem_read && ex_match_s;
      end else begin
         // Without forwarding every in-flight write to a source must retire first.
         hazard_s = (ex_mem_read && ex_match_s) || (ex_wb_en && ex_match_s) ||
                    (mem_wb_en && mem_match_s);
      end
   end

   // Next-state and control outputs; outputs forced low while reset is held.
   always_comb begin
      state_d       = state_q;
      fcnt_d        = fcnt_q;
      pc_freeze     = 1'b0;
      if_id_freeze  = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b0;
      ex_mem_freeze = 1'b0;
      flush_inc_s   = 1'b0;
      if (rst) begin
         case (state_q)
            ST_RUN: begin
               // Priority: dmem stall > branch > data hazard > imem miss.
               if (dmem_req && !dmem_ready) begin
                  pc_freeze     = 1'b1;
                  if_id_freeze  = 1'b1;
                  id_ex_bubble  = 1'b1;
                  ex_mem_freeze = 1'b1;
                  state_d       = ST_DWAIT;
               end else if (branch_taken) begin
                  if_id_flush  = 1'b1;
                  id_ex_bubble = 1'b1;
                  flush_inc_s  = 1'b1;
                  if (FLUSH_CYC > 1) begin
                     state_d = ST_FLUSH;
                     fcnt_d  = FLUSH_RELOAD;
                  end else begin
                     state_d = ST_RUN;
                     fcnt_d  = 2'd0;
                  end
               end else if (hazard_s) begin
                  pc_freeze    = 1'b1;
                  if_id_freeze = 1'b1;
                  id_ex_bubble = 1'b1;
               end else if (!imem_ready) begin
                  pc_freeze   = 1'b1;
                  if_id_flush = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_DWAIT: begin
               // Branches are ignored here; they are re-presented once back in RUN.
               if (!dmem_ready) begin
                  pc_freeze     = 1'b1;
                  if_id_freeze  = 1'b1;
                  id_ex_bubble  = 1'b1;
                  ex_mem_freeze = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_FLUSH: begin
               if_id_flush = 1'b1;
               if (branch_taken) begin
                  fcnt_d      = FLUSH_RELOAD;
                  flush_inc_s = 1'b1;
               end else if (fcnt_q <= 2'd1) begin
                  state_d = ST_RUN;
                  fcnt_d  = 2'd0;
               end else begin
                  fcnt_d = fcnt_q - 2'd1;
               end
            end
            default: begin
               // Encoding 3 is unreachable; recover to RUN.
               state_d = ST_RUN;
               fcnt_d  = 2'd0;
            end
         endcase
      end else begin
         state_d = ST_RUN;
         fcnt_d  = 2'd0;
      end
   end

   // Saturating performance counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (pc_freeze && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (flush_inc_s && (flush_cnt_q != 16'hFFFF)) begin
         flush_cnt_d = flush_cnt_q + 16'd1;
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // State, flush counter and performance counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         fcnt_q      <= 2'd0;
         stall_cnt_q <= 16'd0;
         flush_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         fcnt_q      <= fcnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign state     = state_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: table-driven single-cycle vectors plus
// hand-written multi-cycle sequences. Two instances share the inputs:
// dut (FORWARD_EN=1, FLUSH_CYC=3) and dut_nf (FORWARD_EN=0, FLUSH_CYC=1).
module tb_pipe_hazard_ctrl;

   logic        clk;
   logic        rst;
   logic [4:0]  id_src1, id_src2, ex_dest, mem_dest;
   logic        id_two_src, ex_mem_read, ex_wb_en, mem_wb_en;
   logic        branch_taken, dmem_req, dmem_ready, imem_ready;

   logic        pc_freeze, if_id_freeze, if_id_flush, id_ex_bubble, ex_mem_freeze;
   logic [1:0]  state;
   logic [15:0] stall_cnt, flush_cnt;
   logic        nf_pc_freeze, nf_if_id_freeze, nf_if_id_flush, nf_id_ex_bubble, nf_ex_mem_freeze;
   logic [1:0]  nf_state;
   logic [15:0] nf_stall_cnt, nf_flush_cnt;

   logic [4:0]  ctl, ctl_nf;
   int          n_checks;
   int          n_errors;

   assign ctl    = {pc_freeze, if_id_freeze, if_id_flush, id_ex_bubble, ex_mem_freeze};
   assign ctl_nf = {nf_pc_freeze, nf_if_id_freeze, nf_if_id_flush, nf_id_ex_bubble, nf_ex_mem_freeze};

   pipe_hazard_ctrl #(.FORWARD_EN(1), .FLUSH_CYC(3)) dut (
      .clk(clk), .rst(rst),
      .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
      .ex_dest(ex_dest), .ex_mem_read(ex_mem_read), .ex_wb_en(ex_wb_en),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
      .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .imem_ready(imem_ready),
      .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze), .if_id_flush(if_id_flush),
      .id_ex_bubble(id_ex_bubble), .ex_mem_freeze(ex_mem_freeze),
      .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipe_hazard_ctrl #(.FORWARD_EN(0), .FLUSH_CYC(1)) dut_nf (
      .clk(clk), .rst(rst),
      .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
      .ex_dest(ex_dest), .ex_mem_read(ex_mem_read), .ex_wb_en(ex_wb_en),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
      .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .imem_ready(imem_ready),
      .pc_freeze(nf_pc_freeze), .if_id_freeze(nf_if_id_freeze), .if_id_flush(nf_if_id_flush),
      .id_ex_bubble(nf_id_ex_bubble), .ex_mem_freeze(nf_ex_mem_freeze),
      .state(nf_state), .stall_cnt(nf_stall_cnt), .flush_cnt(nf_flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  s1;
      logic [4:0]  s2;
      logic        two;
      logic [4:0]  exd;
      logic        mr;
      logic        ewb;
      logic [4:0]  md;
      logic        mwb;
      logic        br;
      logic        dreq;
      logic        drdy;
      logic        irdy;
      logic [4:0]  ctl;
      logic [4:0]  ctl_nf;
      logic [1:0]  st;
      logic [1:0]  st_nf;
      logic [15:0] scnt;
      logic [15:0] fcnt;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_src1 = 5'd0; id_src2 = 5'd0; id_two_src = 1'b0;
      ex_dest = 5'd0; ex_mem_read = 1'b0; ex_wb_en = 1'b0;
      mem_dest = 5'd0; mem_wb_en = 1'b0;
      branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
   endtask

   // Pulse reset between clock edges (caller is 1 time unit after a rising edge).
   task automatic do_reset();
      rst = 1'b0;
      #2;
      rst = 1'b1;
      #1;
   endtask

   int flush_seen;

   initial begin
      n_checks = 0;
      n_errors = 0;
      idle_inputs();
      rst = 1'b0;

      //                s1    s2    two   exd   mr    ewb   md    mwb   br    dreq  drdy  irdy  ctl       ctl_nf    st    st_nf scnt   fcnt
      vecs[0]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, 5'b00000, 2'd0, 2'd0, 16'd0, 16'd0};
      vecs[1]  = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11010, 5'b11010, 2'd0, 2'd0, 16'd1, 16'd0};
      vecs[2]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, 5'b00000, 2'd0, 2'd0, 16'd0, 16'd0};
      vecs[3]  = '{5'd1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, 5'b00000, 2'd0, 2'd0, 16'd0, 16'd0};
      vecs[4]  = '{5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11010, 5'b11010, 2'd0, 2'd0, 16'd1, 16'd0};
      vecs[5]  = '{5'd6, 5'd0, 1'b0, 5'd6, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, 5'b11010, 2'd0, 2'd0, 16'd0, 16'd0};
      vecs[6]  = '{5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, 5'b11010, 2'd0, 2'd0, 16'd0, 16'd0};
      vecs[7]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, 5'b00000, 2'd0, 2'd0, 16'd0, 16'd0};
      vecs[8]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'b00110, 5'b00110, 2'd2, 2'd0, 16'd0, 16'd1};
      vecs[9]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'b11011, 5'b11011, 2'd1, 2'd1, 16'd1, 16'd0};
      vecs[10] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'b00000, 5'b00000, 2'd0, 2'd0, 16'd0, 16'd0};
      vecs[11] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10100, 5'b10100, 2'd0, 2'd0, 16'd1, 16'd0};
      vecs[12] = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00110, 5'b00110, 2'd2, 2'd0, 16'd0, 16'd1};
      vecs[13] = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'b11011, 5'b11011, 2'd1, 2'd1, 16'd1, 16'd0};
      vecs[14] = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b11010, 5'b11010, 2'd0, 2'd0, 16'd1, 16'd0};

      // Reset state, held across a clock edge.
      tick();
      check("rst_ctl", {11'd0, ctl}, 16'd0);
      check("rst_state", {14'd0, state}, 16'd0);
      check("rst_stall_cnt", stall_cnt, 16'd0);
      check("rst_flush_cnt", flush_cnt, 16'd0);
      rst = 1'b1;
      tick();

      // Table: each vector from a fresh RUN state, one clock applied.
      for (int i = 0; i < 15; i++) begin
         do_reset();
         id_src1 = vecs[i].s1; id_src2 = vecs[i].s2; id_two_src = vecs[i].two;
         ex_dest = vecs[i].exd; ex_mem_read = vecs[i].mr; ex_wb_en = vecs[i].ewb;
         mem_dest = vecs[i].md; mem_wb_en = vecs[i].mwb;
         branch_taken = vecs[i].br; dmem_req = vecs[i].dreq;
         dmem_ready = vecs[i].drdy; imem_ready = vecs[i].irdy;
         #1;
         check($sformatf("vec%0d_ctl", i), {11'd0, ctl}, {11'd0, vecs[i].ctl});
         check($sformatf("vec%0d_ctl_nf", i), {11'd0, ctl_nf}, {11'd0, vecs[i].ctl_nf});
         tick();
         check($sformatf("vec%0d_state", i), {14'd0, state}, {14'd0, vecs[i].st});
         check($sformatf("vec%0d_state_nf", i), {14'd0, nf_state}, {14'd0, vecs[i].st_nf});
         check($sformatf("vec%0d_stall_cnt", i), stall_cnt, vecs[i].scnt);
         check($sformatf("vec%0d_flush_cnt", i), flush_cnt, vecs[i].fcnt);
         idle_inputs();
      end

      // Data-memory wait of 3 cycles with a branch held throughout.
      do_reset();
      dmem_req = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("dwait_ctl_c%0d", i), {11'd0, ctl}, 16'b11011);
         check($sformatf("dwait_state_c%0d", i), {14'd0, state}, (i == 0) ? 16'd0 : 16'd1);
         tick();
      end
      dmem_ready = 1'b1;
      #1;
      check("dwait_ready_ctl", {11'd0, ctl}, 16'd0);
      check("dwait_ready_state", {14'd0, state}, 16'd1);
      tick();
      check("dwait_exit_state", {14'd0, state}, 16'd0);
      check("dwait_stall_cnt", stall_cnt, 16'd3);
      check("dwait_flush_cnt", flush_cnt, 16'd0);
      dmem_req = 1'b0;
      #1;
      check("dwait_branch_ctl", {11'd0, ctl}, 16'b00110);
      tick();
      check("dwait_branch_flush_cnt", flush_cnt, 16'd1);
      idle_inputs();

      // Single branch pulse with FLUSH_CYC=3: three flush cycles.
      do_reset();
      flush_seen = 0;
      branch_taken = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (if_id_flush) flush_seen = flush_seen + 1;
         tick();
         branch_taken = 1'b0;
      end
      check("flush1_cycles", 16'(flush_seen), 16'd3);
      check("flush1_flush_cnt", flush_cnt, 16'd1);
      check("flush1_state", {14'd0, state}, 16'd0);

      // Second branch in the second flush cycle: four flush cycles total.
      do_reset();
      flush_seen = 0;
      for (int i = 0; i < 8; i++) begin
         branch_taken = (i < 2) ? 1'b1 : 1'b0;
         #1;
         if (if_id_flush) flush_seen = flush_seen + 1;
         tick();
      end
      check("flush2_cycles", 16'(flush_seen), 16'd4);
      check("flush2_flush_cnt", flush_cnt, 16'd2);
      idle_inputs();

      // Reset asserted mid-DWAIT aborts at once; first cycle after is RUN.
      do_reset();
      dmem_req = 1'b1; dmem_ready = 1'b0;
      tick();
      tick();
      check("abort_pre_state", {14'd0, state}, 16'd1);
      check("abort_pre_stall_cnt", stall_cnt, 16'd2);
      rst = 1'b0;
      #1;
      check("abort_ctl", {11'd0, ctl}, 16'd0);
      check("abort_state", {14'd0, state}, 16'd0);
      check("abort_stall_cnt", stall_cnt, 16'd0);
      tick();
      check("abort_held_ctl", {11'd0, ctl}, 16'd0);
      check("abort_held_stall_cnt", stall_cnt, 16'd0);
      rst = 1'b1;
      #1;
      check("abort_run_ctl", {11'd0, ctl}, 16'b11011);
      check("abort_run_state", {14'd0, state}, 16'd0);

      // Stall counter saturation: remain in DWAIT well past 65535 freezes.
      repeat (65540) @(posedge clk);
      #1;
      check("sat_stall_cnt", stall_cnt, 16'hFFFF);
      check("sat_state", {14'd0, state}, 16'd1);
      idle_inputs();

      // Reset asserted mid-FLUSH aborts the flush sequence.
      do_reset();
      branch_taken = 1'b1;
      tick();
      branch_taken = 1'b0;
      check("fabort_pre_state", {14'd0, state}, 16'd2);
      rst = 1'b0;
      #1;
      check("fabort_ctl", {11'd0, ctl}, 16'd0);
      check("fabort_flush_cnt", flush_cnt, 16'd0);
      rst = 1'b1;
      #1;
      check("fabort_run_ctl", {11'd0, ctl}, 16'd0);
      tick();
      check("fabort_run_state", {14'd0, state}, 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
